// File: rtl/adder_operand_pairer.sv
// adder_operand_pairer: buffers two operand streams and issues aligned op1/op2/cin triples to the adder.
// Optional credit gating against the downstream result buffer: define ADDER_PAIRER_CREDIT_EN.
module adder_operand_pairer #(
    parameter int W       = 128,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] a_data,
    input  logic         a_cin,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [W-1:0] b_data,
    input  logic         b_valid,
    output logic         b_ready,
    output logic [W-1:0] op1,
    output logic [W-1:0] op2,
    output logic         cin,
    output logic         valid_op1,
    output logic         valid_op2,
    input  logic         credit_ret,
    output logic [7:0]   credits,
    output logic         credit_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [W:0]   mem_a_q [DEPTH];
    logic [W-1:0] mem_b_q [DEPTH];
    logic [AW:0]  wa_q, wa_d, ra_q, ra_d, wb_q, wb_d, rb_q, rb_d;
    logic [W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic         cin_q, cin_d, vld_q, vld_d;
    logic         full_a, full_b, empty_a, empty_b, push_a, push_b, credit_ok, issue;
    logic [W:0]   head_a;

    assign full_a  = (wa_q[AW-1:0] == ra_q[AW-1:0]) && (wa_q[AW] != ra_q[AW]);
    assign full_b  = (wb_q[AW-1:0] == rb_q[AW-1:0]) && (wb_q[AW] != rb_q[AW]);
    assign empty_a = wa_q == ra_q;
    assign empty_b = wb_q == rb_q;
    assign a_ready = !full_a;
    assign b_ready = !full_b;
    assign push_a  = a_valid && !full_a;
    assign push_b  = b_valid && !full_b;
    assign issue   = !empty_a && !empty_b && credit_ok;
    assign head_a  = mem_a_q[ra_q[AW-1:0]];

    assign op1       = op1_q;
    assign op2       = op2_q;
    assign cin       = cin_q;
    assign valid_op1 = vld_q;
    assign valid_op2 = vld_q;

`ifdef ADDER_PAIRER_CREDIT_EN
    logic [7:0] credits_q, credits_d;
    logic       err_q, err_d;

    // Issue spends a credit, credit_ret refunds one; a refund into a full count is flagged sticky.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (issue && !credit_ret)
            credits_d = credits_q - 8'd1;
        else if (!issue && credit_ret) begin
            if (credits_q == 8'(CREDITS))
                err_d = 1'b1;
            else
                credits_d = credits_q + 8'd1;
        end
    end

    // Credit state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            credits_q <= 8'(CREDITS);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credit_ok  = credits_q != 8'd0;
    assign credits    = credits_q;
    assign credit_err = err_q;
`else
    logic unused_credit_ret;
    assign unused_credit_ret = credit_ret;
    assign credit_ok  = 1'b1;
    assign credits    = 8'(CREDITS);
    assign credit_err = 1'b0;
`endif

    // Pointer advance and output staging: both FIFOs pop together on issue.
    always_comb begin
        wa_d  = push_a ? wa_q + ONE : wa_q;
        wb_d  = push_b ? wb_q + ONE : wb_q;
        ra_d  = issue ? ra_q + ONE : ra_q;
        rb_d  = issue ? rb_q + ONE : rb_q;
        op1_d = issue ? head_a[W-1:0] : op1_q;
        cin_d = issue ? head_a[W] : cin_q;
        op2_d = issue ? mem_b_q[rb_q[AW-1:0]] : op2_q;
        vld_d = issue;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wa_q  <= '0;
            ra_q  <= '0;
            wb_q  <= '0;
            rb_q  <= '0;
            op1_q <= '0;
            op2_q <= '0;
            cin_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            wa_q  <= wa_d;
            ra_q  <= ra_d;
            wb_q  <= wb_d;
            rb_q  <= rb_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            cin_q <= cin_d;
            vld_q <= vld_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_a)
            mem_a_q[wa_q[AW-1:0]] <= {a_cin, a_data};
        if (push_b)
            mem_b_q[wb_q[AW-1:0]] <= b_data;
    end
endmodule
